// File: rtl/chacha20_poly1305_seq.sv
// chacha20_poly1305_seq: host-side AEAD message sequencer in front of
// chacha20_poly1305_core (cfg, AAD, payload XOR keystream, length block, tag).
module chacha20_poly1305_seq #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec,
  input  logic [LEN_W-1:0] aad_len,
  input  logic [LEN_W-1:0] pld_len,
  input  logic [127:0]     exp_tag,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [15:0]      in_keep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [15:0]      out_keep,
  output logic             busy,
  output logic [127:0]     tag,
  output logic             tag_valid,
  output logic             auth_ok,
  output logic             cfg_we,
  output logic             ks_req,
  input  logic             ks_valid,
  input  logic [511:0]     ks_data,
  output logic             aad_valid,
  output logic [127:0]     aad_data,
  output logic [15:0]      aad_keep,
  input  logic             aad_ready,
  output logic             pld_valid,
  output logic [127:0]     pld_data,
  output logic [15:0]      pld_keep,
  input  logic             pld_ready,
  output logic             len_valid,
  output logic [127:0]     len_block,
  input  logic             len_ready,
  input  logic [127:0]     tag_pre_xor,
  input  logic             tag_pre_xor_valid,
  input  logic [127:0]     tagmask,
  input  logic             tagmask_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_AAD, S_PLD, S_LEN, S_TAG, S_DONE
  } state_t;

  state_t state, state_n;

  logic             dec_r;
  logic [LEN_W-1:0] aad_len_r, pld_len_r, rem;
  logic [127:0]     exp_tag_r;
  logic [511:0]     ks_buf;
  logic             ks_full, ks_pend;
  logic [1:0]       lane_idx;
  logic [127:0]     x_r, p_r;
  logic [15:0]      keep_r;
  logic             ov, pv, last_r;
  logic [127:0]     pre_r, mask_r, tag_r;
  logic             pre_ok, mask_ok, tag_v, auth_r;

  logic             go, last_beat, drain, ks_load;
  logic             acc_aad, acc_pld;
  logic [127:0]     lane, x_n, pmask;
  logic [15:0]      keep_n;
  logic             unused;

  function automatic logic [LEN_W-1:0] beats(
    input logic [LEN_W-1:0] n
  );
    return (n >> 4) + LEN_W'(|n[3:0]);
  endfunction

  function automatic logic [15:0] tail_keep(
    input logic [3:0] m
  );
    return (m == 4'd0) ? 16'hFFFF
                       : 16'((17'd1 << m) - 17'd1);
  endfunction

  function automatic logic [127:0] byte_mask(
    input logic [15:0] k
  );
    logic [127:0] m;
    for (int i = 0; i < 16; i++)
      m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  assign unused    = ^in_keep;
  assign go        = start & ~abort &
                     (state == S_IDLE || state == S_DONE);
  assign last_beat = (rem == LEN_W'(1));
  assign ks_load   = ks_valid & ks_pend;
  assign lane      = ks_buf[{lane_idx, 7'd0} +: 128];
  assign keep_n    = last_beat ? tail_keep(pld_len_r[3:0])
                               : 16'hFFFF;
  assign pmask     = byte_mask(keep_n);
  assign x_n       = (in_data ^ lane) & pmask;
  assign drain     = (ov | pv) & (~ov | out_ready) &
                     (~pv | pld_ready);
  assign acc_aad   = (state == S_AAD) & in_valid & in_ready;
  assign acc_pld   = (state == S_PLD) & in_valid & in_ready;

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    aad_valid = 1'b0;
    cfg_we    = 1'b0;
    ks_req    = 1'b0;
    len_valid = 1'b0;
    unique case (state)
      S_IDLE: if (go) state_n = S_CFG;
      S_CFG: begin
        cfg_we = 1'b1;
        if (aad_len_r != '0)      state_n = S_AAD;
        else if (pld_len_r != '0) state_n = S_PLD;
        else                      state_n = S_LEN;
      end
      S_AAD: begin
        in_ready  = aad_ready;
        aad_valid = in_valid;
        if (in_valid & aad_ready & last_beat)
          state_n = (pld_len_r != '0) ? S_PLD : S_LEN;
      end
      S_PLD: begin
        in_ready = ks_full & ~ov & ~pv & (rem != '0);
        ks_req   = ~ks_full & ~ks_pend & (rem != '0);
        if (drain & last_r) state_n = S_LEN;
      end
      S_LEN: begin
        len_valid = 1'b1;
        if (len_ready) state_n = S_TAG;
      end
      S_TAG: if (pre_ok & mask_ok) state_n = S_DONE;
      S_DONE: state_n = go ? S_CFG : S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // abort squashes every same-cycle handshake and pulse
    if (abort) begin
      state_n   = S_IDLE;
      in_ready  = 1'b0;
      aad_valid = 1'b0;
      cfg_we    = 1'b0;
      ks_req    = 1'b0;
      len_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dec_r     <= 1'b0;
      aad_len_r <= '0;
      pld_len_r <= '0;
      exp_tag_r <= '0;
      rem       <= '0;
      ks_buf    <= '0;
      ks_full   <= 1'b0;
      ks_pend   <= 1'b0;
      lane_idx  <= 2'd0;
      x_r       <= '0;
      p_r       <= '0;
      keep_r    <= '0;
      ov        <= 1'b0;
      pv        <= 1'b0;
      last_r    <= 1'b0;
      pre_r     <= '0;
      mask_r    <= '0;
      tag_r     <= '0;
      pre_ok    <= 1'b0;
      mask_ok   <= 1'b0;
      tag_v     <= 1'b0;
      auth_r    <= 1'b0;
    end else begin
      state <= state_n;
      if (abort) begin
        rem     <= '0;
        ks_full <= 1'b0;
        ks_pend <= 1'b0;
        ov      <= 1'b0;
        pv      <= 1'b0;
        last_r  <= 1'b0;
        pre_ok  <= 1'b0;
        mask_ok <= 1'b0;
        tag_v   <= 1'b0;
        tag_r   <= '0;
        auth_r  <= 1'b0;
      end else begin
        if (go) begin
          dec_r     <= dec;
          aad_len_r <= aad_len;
          pld_len_r <= pld_len;
          exp_tag_r <= exp_tag;
          tag_v     <= 1'b0;
          auth_r    <= 1'b0;
        end
        if (state == S_CFG) begin
          ks_full <= 1'b0;
          ks_pend <= 1'b0;
          pre_ok  <= 1'b0;
          mask_ok <= 1'b0;
          last_r  <= 1'b0;
          rem     <= (aad_len_r != '0) ? beats(aad_len_r)
                                       : beats(pld_len_r);
        end
        if (acc_aad)
          rem <= last_beat ? beats(pld_len_r)
                           : rem - LEN_W'(1);
        if (ks_req) ks_pend <= 1'b1;
        if (ks_load) begin
          ks_buf   <= ks_data;
          ks_full  <= 1'b1;
          ks_pend  <= 1'b0;
          lane_idx <= 2'd0;
        end
        if (acc_pld) begin
          x_r      <= x_n;
          p_r      <= dec_r ? (in_data & pmask) : x_n;
          keep_r   <= keep_n;
          ov       <= 1'b1;
          pv       <= 1'b1;
          last_r   <= last_beat;
          rem      <= rem - LEN_W'(1);
          lane_idx <= lane_idx + 2'd1;
          if (lane_idx == 2'd3) ks_full <= 1'b0;
        end else begin
          if (out_ready) ov <= 1'b0;
          if (pld_ready) pv <= 1'b0;
        end
        if (state == S_TAG) begin
          if (tag_pre_xor_valid & ~pre_ok) begin
            pre_r  <= tag_pre_xor;
            pre_ok <= 1'b1;
          end
          if (tagmask_valid & ~mask_ok) begin
            mask_r  <= tagmask;
            mask_ok <= 1'b1;
          end
          if (pre_ok & mask_ok) begin
            tag_r  <= pre_r ^ mask_r;
            tag_v  <= 1'b1;
            auth_r <= dec_r &
                      ((pre_r ^ mask_r) == exp_tag_r);
          end
        end
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign out_valid = ov;
  assign out_data  = x_r;
  assign out_keep  = keep_r;
  assign pld_valid = pv;
  assign pld_data  = p_r;
  assign pld_keep  = keep_r;
  assign aad_data  = (state == S_AAD) ? in_data : '0;
  assign aad_keep  = (state != S_AAD) ? 16'h0000 :
                     last_beat ? tail_keep(aad_len_r[3:0])
                               : 16'hFFFF;
  assign len_block = {64'(pld_len_r), 64'(aad_len_r)};
  assign tag       = tag_r;
  assign tag_valid = tag_v;
  assign auth_ok   = auth_r;

endmodule
